// File: rtl/dcache_ctrl_fsm_pkg.sv
// Shared definitions for the cache controller slice.
// Holds the controller state type, the default line size and the helper that
// derives the beat counter width from the line size.
package dcache_ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } t_cache_state;

    localparam int unsigned DEFAULT_BLOCK_WORDS = 16;

    // A one-word line still needs a 1-bit index so the port never collapses
    // to zero width.
    function automatic int unsigned beat_width(input int unsigned words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_ctrl_fsm_beat_counter.sv
// Beat counter for cache line bursts.
// Counts words within a line, wrapping modulo BLOCK_WORDS.
// Ports:
//   clk, arstn  clock and asynchronous active-low reset
//   clr         clear to 0 (wins over inc)
//   inc         advance by one beat
//   count       current beat index
//   last        count is the final word of the line
module dcache_ctrl_fsm_beat_counter
    import dcache_ctrl_fsm_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int unsigned BEAT_W      = beat_width(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              clr,
    input  logic              inc,
    output logic [BEAT_W-1:0] count,
    output logic              last
);

    localparam logic [BEAT_W-1:0] LastIdx = BEAT_W'(BLOCK_WORDS - 1);

    logic [BEAT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (count_q == LastIdx) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LastIdx);

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// Direct-mapped write-back, write-allocate cache controller FSM.
// Answers the main FSM's held start strobe with a same-cycle stall, completes
// hits in IDLE, and runs a write-back burst (dirty victim) followed by a
// refill burst on a miss. After refill the access is re-checked in IDLE.
// Ports:
//   clk, arstn           clock and asynchronous active-low reset
//   i_start/i_write      access request and store flag
//   i_hit/i_dirty        tag compare result and victim dirty bit
//   i_mem_rvalid         read beat valid; i_mem_wready write beat accepted
//   o_stall              core must hold its request
//   o_data_we/o_dirty_set store hit: write word, mark line dirty
//   o_refill_we          write memory beat at o_beat_idx
//   o_meta_we            write tag, set valid, clear dirty (last refill beat)
//   o_mem_rd_req/o_mem_wr_req  read / write-back burst active
//   o_beat_idx           word within the line; o_mem_wlast final write beat
module dcache_ctrl_fsm
    import dcache_ctrl_fsm_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int unsigned BEAT_W      = beat_width(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              i_start,
    input  logic              i_write,
    input  logic              i_hit,
    input  logic              i_dirty,
    input  logic              i_mem_rvalid,
    input  logic              i_mem_wready,
    output logic              o_stall,
    output logic              o_data_we,
    output logic              o_dirty_set,
    output logic              o_refill_we,
    output logic              o_meta_we,
    output logic              o_mem_rd_req,
    output logic              o_mem_wr_req,
    output logic [BEAT_W-1:0] o_beat_idx,
    output logic              o_mem_wlast
);

    t_cache_state      state_q, state_d;
    logic              cnt_clr, cnt_inc, cnt_last;
    logic [BEAT_W-1:0] cnt;

    dcache_ctrl_fsm_beat_counter #(
        .BLOCK_WORDS(BLOCK_WORDS),
        .BEAT_W     (BEAT_W)
    ) u_beat_counter (
        .clk  (clk),
        .arstn(arstn),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        o_stall      = 1'b0;
        o_data_we    = 1'b0;
        o_dirty_set  = 1'b0;
        o_refill_we  = 1'b0;
        o_meta_we    = 1'b0;
        o_mem_rd_req = 1'b0;
        o_mem_wr_req = 1'b0;
        o_beat_idx   = '0;
        o_mem_wlast  = 1'b0;

        case (state_q)
            IDLE: begin
                o_stall = i_start & ~i_hit;
                if (i_start && i_hit) begin
                    o_data_we   = i_write;
                    o_dirty_set = i_write;
                end else if (i_start) begin
                    state_d = i_dirty ? WRITE_BACK : ALLOCATE;
                    cnt_clr = 1'b1;
                end
            end
            WRITE_BACK: begin
                o_stall      = 1'b1;
                o_mem_wr_req = 1'b1;
                o_beat_idx   = cnt;
                o_mem_wlast  = cnt_last;
                if (i_mem_wready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ALLOCATE;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ALLOCATE: begin
                o_stall      = 1'b1;
                o_mem_rd_req = 1'b1;
                o_beat_idx   = cnt;
                o_refill_we  = i_mem_rvalid;
                if (i_mem_rvalid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        // Line becomes valid only here, so an aborted refill
                        // leaves it invalid.
                        o_meta_we = 1'b1;
                        state_d   = IDLE;
                        cnt_clr   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Bench for dcache_ctrl_fsm: a 16-word and a 1-word instance share stimulus.
// A burst-level model (write beats left, read beats left) predicts every
// output every cycle; directed scenarios pin beat counts with literals.
module tb_dcache_ctrl_fsm;

    logic clk = 1'b0;
    logic arstn;
    logic start, write, hit, dirty, rvalid, wready;

    logic       a_stall, a_dwe, a_dset, a_rwe, a_mwe, a_rd, a_wr, a_wl;
    logic [3:0] a_idx;
    logic       b_stall, b_dwe, b_dset, b_rwe, b_mwe, b_rd, b_wr, b_wl;
    logic [0:0] b_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dcache_ctrl_fsm #(.BLOCK_WORDS(16), .BEAT_W(4)) u_dut16 (
        .clk(clk), .arstn(arstn), .i_start(start), .i_write(write), .i_hit(hit),
        .i_dirty(dirty), .i_mem_rvalid(rvalid), .i_mem_wready(wready),
        .o_stall(a_stall), .o_data_we(a_dwe), .o_dirty_set(a_dset), .o_refill_we(a_rwe),
        .o_meta_we(a_mwe), .o_mem_rd_req(a_rd), .o_mem_wr_req(a_wr), .o_beat_idx(a_idx),
        .o_mem_wlast(a_wl)
    );

    dcache_ctrl_fsm #(.BLOCK_WORDS(1), .BEAT_W(1)) u_dut1 (
        .clk(clk), .arstn(arstn), .i_start(start), .i_write(write), .i_hit(hit),
        .i_dirty(dirty), .i_mem_rvalid(rvalid), .i_mem_wready(wready),
        .o_stall(b_stall), .o_data_we(b_dwe), .o_dirty_set(b_dset), .o_refill_we(b_rwe),
        .o_meta_we(b_mwe), .o_mem_rd_req(b_rd), .o_mem_wr_req(b_wr), .o_beat_idx(b_idx),
        .o_mem_wlast(b_wl)
    );

    typedef struct packed {
        logic       stall, data_we, dirty_set, refill_we, meta_we, rd_req, wr_req, wlast;
        logic [5:0] idx;
    } obs_t;

    typedef struct {
        int refill, idxsum, meta, stall, wbeat, wlast, badwlast, dset;
    } evc_t;

    evc_t ev16 = '{default: 0};
    evc_t ev1  = '{default: 0};

    // Model state: beats still owed in each burst; idle when both are zero.
    int m16_wb = 0, m16_rd = 0, m1_wb = 0, m1_rd = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t predict(input int bw, input int wb_left, input int rd_left,
                                     input logic st, input logic wr, input logic h,
                                     input logic rv);
        obs_t o = '0;
        if (wb_left > 0) begin
            o.stall  = 1'b1;
            o.wr_req = 1'b1;
            o.idx    = 6'(bw - wb_left);
            o.wlast  = (wb_left == 1);
        end else if (rd_left > 0) begin
            o.stall     = 1'b1;
            o.rd_req    = 1'b1;
            o.idx       = 6'(bw - rd_left);
            o.refill_we = rv;
            o.meta_we   = rv && (rd_left == 1);
        end else begin
            o.stall     = st && !h;
            o.data_we   = st && h && wr;
            o.dirty_set = st && h && wr;
        end
        return o;
    endfunction

    task automatic advance(input int bw, inout int wb_left, inout int rd_left, input logic st,
                           input logic h, input logic d, input logic rv, input logic wrdy);
        if (wb_left > 0) begin
            if (wrdy) wb_left--;
        end else if (rd_left > 0) begin
            if (rv) rd_left--;
        end else if (st && !h) begin
            wb_left = d ? bw : 0;
            rd_left = bw;
        end
    endtask

    function automatic obs_t obs16();
        obs_t o;
        o.stall = a_stall; o.data_we = a_dwe; o.dirty_set = a_dset; o.refill_we = a_rwe;
        o.meta_we = a_mwe; o.rd_req = a_rd; o.wr_req = a_wr; o.wlast = a_wl;
        o.idx = 6'(a_idx);
        return o;
    endfunction

    function automatic obs_t obs1();
        obs_t o;
        o.stall = b_stall; o.data_we = b_dwe; o.dirty_set = b_dset; o.refill_we = b_rwe;
        o.meta_we = b_mwe; o.rd_req = b_rd; o.wr_req = b_wr; o.wlast = b_wl;
        o.idx = 6'(b_idx);
        return o;
    endfunction

    // Compare process: outputs are settled mid-cycle, inputs change after posedge.
    always @(negedge clk) begin
        obs_t e16, e1;
        if (!arstn) begin
            m16_wb = 0; m16_rd = 0; m1_wb = 0; m1_rd = 0;
        end
        e16 = predict(16, m16_wb, m16_rd, start, write, hit, rvalid);
        e1  = predict(1, m1_wb, m1_rd, start, write, hit, rvalid);
        check("dut16 outputs", 64'(obs16()), 64'(e16));
        check("dut1 outputs", 64'(obs1()), 64'(e1));
        if (arstn) begin
            advance(16, m16_wb, m16_rd, start, hit, dirty, rvalid, wready);
            advance(1, m1_wb, m1_rd, start, hit, dirty, rvalid, wready);
        end
        ev16.refill   += int'(a_rwe);
        ev16.idxsum   += a_rwe ? int'(a_idx) : 0;
        ev16.meta     += int'(a_mwe);
        ev16.stall    += int'(a_stall);
        ev16.wbeat    += int'(a_wr && wready);
        ev16.wlast    += int'(a_wl && a_wr && wready);
        ev16.badwlast += int'(a_wl && (a_idx != 4'd15));
        ev16.dset     += int'(a_dset);
        ev1.refill    += int'(b_rwe);
        ev1.meta      += int'(b_mwe);
        ev1.stall     += int'(b_stall);
        ev1.wbeat     += int'(b_wr && wready);
        ev1.wlast     += int'(b_wl && b_wr && wready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        evc_t s;
        logic done;
        int   hold;

        arstn = 1'b0; start = 1'b0; write = 1'b0; hit = 1'b0; dirty = 1'b0;
        rvalid = 1'b0; wready = 1'b0;
        tick();
        tick();
        check("reset outputs dut16", 64'(obs16()), 64'd0);
        check("reset outputs dut1", 64'(obs1()), 64'd0);
        arstn = 1'b1;
        tick();

        // Read hit: no stall, no write, no memory traffic.
        start = 1'b1; write = 1'b0; hit = 1'b1;
        #1;
        check("read hit stall", 64'(a_stall), 64'd0);
        check("read hit data_we", 64'(a_dwe), 64'd0);
        tick();
        check("read hit stays idle", 64'({a_rd, a_wr}), 64'd0);
        start = 1'b0;

        // Write hit: one-cycle data write and dirty set.
        start = 1'b1; write = 1'b1; hit = 1'b1;
        #1;
        check("write hit data_we", 64'(a_dwe), 64'd1);
        check("write hit dirty_set", 64'(a_dset), 64'd1);
        check("write hit no mem req", 64'({a_rd, a_wr}), 64'd0);
        tick();
        start = 1'b0; write = 1'b0;
        #1;
        check("write hit pulse ends", 64'(a_dwe), 64'd0);

        // Clean read miss, rvalid every other cycle.
        s = ev16; done = 1'b0;
        start = 1'b1; write = 1'b0; hit = 1'b0; dirty = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            rvalid = (k % 2 == 1);
            tick();
            if (!a_rd && !a_wr) begin
                hit = 1'b1; rvalid = 1'b0;
                #1;
                check("clean miss recheck stall", 64'(a_stall), 64'd0);
                done = 1'b1;
            end
        end
        if (!done) check("clean miss timeout", 64'd0, 64'd1);
        tick();
        start = 1'b0; hit = 1'b0;
        check("clean miss refill beats", 64'(ev16.refill - s.refill), 64'd16);
        check("clean miss idx sum", 64'(ev16.idxsum - s.idxsum), 64'd120);
        check("clean miss meta_we", 64'(ev16.meta - s.meta), 64'd1);
        check("clean miss stall cycles", 64'(ev16.stall - s.stall), 64'd32);

        // Dirty write miss, wready held off 2 cycles on beat 7.
        s = ev16; done = 1'b0; hold = 0;
        start = 1'b1; write = 1'b1; hit = 1'b0; dirty = 1'b1; rvalid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            wready = !(a_wr && a_idx == 4'd7 && hold < 2);
            if (!wready) hold++;
            tick();
            if (k > 0 && !a_rd && !a_wr) begin
                hit = 1'b1;
                #1;
                check("dirty miss final data_we", 64'(a_dwe), 64'd1);
                done = 1'b1;
            end
        end
        if (!done) check("dirty miss timeout", 64'd0, 64'd1);
        tick();
        start = 1'b0; write = 1'b0; dirty = 1'b0; hit = 1'b0; wready = 1'b0; rvalid = 1'b0;
        check("dirty miss write beats", 64'(ev16.wbeat - s.wbeat), 64'd16);
        check("dirty miss wlast beats", 64'(ev16.wlast - s.wlast), 64'd1);
        check("dirty miss wlast off idx15", 64'(ev16.badwlast - s.badwlast), 64'd0);
        check("dirty miss refill beats", 64'(ev16.refill - s.refill), 64'd16);
        check("dirty miss meta_we", 64'(ev16.meta - s.meta), 64'd1);
        check("dirty miss stall cycles", 64'(ev16.stall - s.stall), 64'd35);
        check("dirty miss dirty_set", 64'(ev16.dset - s.dset), 64'd1);

        // Reset during refill beat 5.
        s = ev16; done = 1'b0;
        start = 1'b1; hit = 1'b0; dirty = 1'b0; rvalid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (a_rd && a_idx == 4'd5) begin
                arstn = 1'b0;
                #1;
                check("reset drops rd_req", 64'(a_rd), 64'd0);
                check("reset drops refill_we", 64'(a_rwe), 64'd0);
                check("reset clears idx", 64'(a_idx), 64'd0);
                check("reset stall idle rule", 64'(a_stall), 64'd1);
                done = 1'b1;
            end
        end
        if (!done) check("reset mid-refill timeout", 64'd0, 64'd1);
        tick();
        check("aborted refill no meta_we", 64'(ev16.meta - s.meta), 64'd0);
        check("aborted refill beats", 64'(ev16.refill - s.refill), 64'd5);
        arstn = 1'b1;
        #1;
        check("after reset in idle", 64'({a_rd, a_wr}), 64'd0);
        tick();
        check("restart allocate", 64'(a_rd), 64'd1);
        check("restart beat 0", 64'(a_idx), 64'd0);
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (!a_rd && !a_wr) begin
                hit = 1'b1;
                done = 1'b1;
            end
        end
        if (!done) check("restart refill timeout", 64'd0, 64'd1);
        tick();
        start = 1'b0; hit = 1'b0; rvalid = 1'b0;

        // One-word line: dirty miss on the 1-word instance.
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        s = ev1; done = 1'b0;
        start = 1'b1; write = 1'b1; hit = 1'b0; dirty = 1'b1; wready = 1'b1; rvalid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (k > 0 && !b_rd && !b_wr) begin
                hit = 1'b1;
                #1;
                check("bw1 final data_we", 64'(b_dwe), 64'd1);
                done = 1'b1;
            end
        end
        if (!done) check("bw1 miss timeout", 64'd0, 64'd1);
        tick();
        start = 1'b0; write = 1'b0; hit = 1'b0; dirty = 1'b0; wready = 1'b0; rvalid = 1'b0;
        check("bw1 write beats", 64'(ev1.wbeat - s.wbeat), 64'd1);
        check("bw1 wlast beats", 64'(ev1.wlast - s.wlast), 64'd1);
        check("bw1 refill beats", 64'(ev1.refill - s.refill), 64'd1);
        check("bw1 meta_we", 64'(ev1.meta - s.meta), 64'd1);
        check("bw1 stall cycles", 64'(ev1.stall - s.stall), 64'd3);

        // Random traffic, including occasional resets, checked by the model.
        for (int k = 0; k < 3000; k++) begin
            arstn  = ($urandom_range(0, 149) != 0);
            start  = ($urandom_range(0, 3) != 0);
            write  = 1'($urandom_range(0, 1));
            hit    = ($urandom_range(0, 2) == 0);
            dirty  = 1'($urandom_range(0, 1));
            rvalid = ($urandom_range(0, 2) != 0);
            wready = ($urandom_range(0, 2) != 0);
            tick();
        end
        arstn = 1'b1; start = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl_fsm.md
Name: dcache_ctrl_fsm

Overview:
- Responder side of the core's cache start/stall handshake. The main control FSM drives a start strobe and holds it; this block answers with a same-cycle stall.
- Controls one direct-mapped, write-back, write-allocate cache: hit handling, dirty-line write-back burst, refill burst.
- Instantiated twice: once as the instruction cache (writes tied low), once as the data cache.
- Drives the tag/data array enables and a simple beat-based memory interface.

Parameters:
- BLOCK_WORDS, 16, words per cache line and beats per burst; power of two, 1 to 64.
- BEAT_W, $clog2(BLOCK_WORDS) with a minimum of 1, width of the beat counter.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- i_start  in  1  access request from the main FSM; held until stall drops
- i_write  in  1  request is a store
- i_hit  in  1  tag match and valid, from tag array compare (combinational)
- i_dirty  in  1  dirty bit of the indexed line
- i_mem_rvalid  in  1  memory read beat valid
- i_mem_wready  in  1  memory accepted current write beat
- o_stall  out  1  core must hold its request
- o_data_we  out  1  write store word into the line on a hit
- o_dirty_set  out  1  set dirty bit of the indexed line
- o_refill_we  out  1  write memory beat into the line at o_beat_idx
- o_meta_we  out  1  write tag, set valid, clear dirty
- o_mem_rd_req  out  1  read burst active
- o_mem_wr_req  out  1  write-back burst active
- o_beat_idx  out  BEAT_W  current word within the line
- o_mem_wlast  out  1  current write beat is the final beat

Behaviour:
- Reset (arstn low, asynchronous): state IDLE, beat counter 0. All outputs are 0 except that o_stall follows the IDLE rule.
- States: IDLE, WRITE_BACK, ALLOCATE. All outputs are combinational from state, counter and inputs.
- IDLE:
  - o_stall = i_start & ~i_hit.
  - On i_start & i_hit, the access completes in this cycle with 0 extra latency:
    - o_data_we = i_write
    - o_dirty_set = i_write
  - On i_start & ~i_hit: next state is WRITE_BACK if i_dirty, else ALLOCATE. Counter is cleared.
  - No i_start: stay in IDLE, all outputs 0.
- WRITE_BACK:
  - o_stall = 1, o_mem_wr_req = 1, o_beat_idx = counter.
  - o_mem_wlast = (counter == BLOCK_WORDS-1).
  - Counter increments on i_mem_wready. A write beat with wlast accepted moves the FSM to ALLOCATE and clears the counter.
  - With no i_mem_wready, hold state and counter.
- ALLOCATE:
  - o_stall = 1, o_mem_rd_req = 1, o_beat_idx = counter.
  - o_refill_we = i_mem_rvalid; counter increments on i_mem_rvalid.
  - On the final beat (counter == BLOCK_WORDS-1 with rvalid): o_meta_we = 1, next state IDLE, counter cleared.
- Re-check after refill: IDLE then sees i_hit = 1 and completes the access. A miss therefore costs BLOCK_WORDS read beats, plus BLOCK_WORDS write beats if the line was dirty, plus 1 cycle.
- Counter wraps modulo BLOCK_WORDS. It never exceeds BLOCK_WORDS-1. It is cleared on every state entry.
- BLOCK_WORDS = 1: single-beat bursts; o_mem_wlast = 1 on the only write beat.
- i_start dropping mid-burst: the burst always completes. The FSM then returns to IDLE with no data write.
- i_mem_rvalid or i_mem_wready outside its matching state is ignored.
- Reset mid-burst: immediate return to IDLE. Requests drop in the same cycle. A partially refilled line stays invalid because o_meta_we was never asserted.
- I-cache instance: i_write = 0, so o_data_we and o_dirty_set are never 1 and i_dirty is always 0.

Decomposition:
- Shared cache package holds:
  - state enum t_cache_state {IDLE, WRITE_BACK, ALLOCATE}
  - default BLOCK_WORDS constant
  - beat-width function
- Beat counter as sub-module beat_counter (clear, increment enable, wrap, last flag).
- FSM and output decode stay in this module.

Test Plan:
- Read hit: i_start=1, i_write=0, i_hit=1 -> o_stall=0 same cycle; o_data_we=0; state stays IDLE.
- Write hit: i_start=1, i_write=1, i_hit=1 -> o_data_we=1 and o_dirty_set=1 for exactly 1 cycle; no memory request.
- Clean read miss, BLOCK_WORDS=16, rvalid every other cycle:
  - o_mem_rd_req high until beat 15; o_refill_we pulses 16 times with o_beat_idx 0 through 15.
  - o_meta_we with beat 15; next cycle IDLE with i_hit=1 -> o_stall=0.
- Dirty write miss: i_dirty=1, wready stalls 2 cycles on beat 7 -> 16 write beats, o_mem_wlast only on idx 15; then 16 refill beats; then the hit write sets dirty. Total stall = 32 beats + stall cycles + 1.
- arstn pulled low at refill beat 5 -> outputs drop immediately; o_meta_we never asserted; after release, i_start with i_hit=0 restarts ALLOCATE at beat 0.
- BLOCK_WORDS=1 build: dirty miss -> 1 write beat with o_mem_wlast=1, then 1 refill beat with o_meta_we=1.
